// File: rtl/universal_shift_engine.sv
// Universal shift register with single-step and burst modes: a 3-state FSM
// runs a latched operation for a clamped number of cycles and pulses done.
module universal_shift_engine #(
  parameter int WIDTH = 8,
  parameter int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic             clk_2,
  input  logic             reset_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             serial_in_r,
  input  logic             serial_in_l,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             start,
  input  logic [CNTW-1:0]  amount,
  output logic [WIDTH-1:0] data_out,
  output logic             serial_out_r,
  output logic             serial_out_l,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHR  = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_ROR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_LOAD = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  localparam logic [CNTW-1:0] AMT_MAX = CNTW'(WIDTH);
  localparam logic [CNTW-1:0] AMT_ONE = CNTW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    DONE_ST = 2'd2
  } state_t;

  state_t           state;
  logic [CNTW-1:0]  rem;
  logic [2:0]       mode_lat;
  logic [WIDTH-1:0] pin_lat;
  logic [CNTW-1:0]  amt_sat;

  // One step of the selected operation; serial bits are taken live.
  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] d,
    input logic [WIDTH-1:0] ld,
    input logic             sr,
    input logic             sl
  );
    logic signed [WIDTH-1:0] ds;
    ds = d;
    case (op)
      M_HOLD:  apply_op = d;
      M_SHR:   apply_op = {sr, d[WIDTH-1:1]};
      M_SHL:   apply_op = {d[WIDTH-2:0], sl};
      M_ROR:   apply_op = {d[0], d[WIDTH-1:1]};
      M_ROL:   apply_op = {d[WIDTH-2:0], d[WIDTH-1]};
      M_LOAD:  apply_op = ld;
      M_ASR:   apply_op = ds >>> 1;
      M_CLR:   apply_op = '0;
      default: apply_op = d;
    endcase
  endfunction

  function automatic logic [CNTW-1:0] sat_amount(input logic [CNTW-1:0] a);
    sat_amount = (a > AMT_MAX) ? AMT_MAX : a;
  endfunction

  assign amt_sat      = sat_amount(amount);
  assign serial_out_r = data_out[0];
  assign serial_out_l = data_out[WIDTH-1];

  // Burst operands are captured on the start edge so later input changes
  // cannot disturb a running burst.
  always_ff @(posedge clk_2) begin
    if (state == IDLE && start) begin
      mode_lat <= mode;
      pin_lat  <= parallel_in;
    end
  end

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      data_out <= '0;
      rem      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (amt_sat != '0) begin
              state <= SHIFT;
              rem   <= amt_sat;
              busy  <= 1'b1;
            end else begin
              state <= DONE_ST;
              done  <= 1'b1;
            end
          end else if (en) begin
            data_out <= apply_op(mode, data_out, parallel_in, serial_in_r, serial_in_l);
          end
        end
        SHIFT: begin
          data_out <= apply_op(mode_lat, data_out, pin_lat, serial_in_r, serial_in_l);
          rem      <= rem - AMT_ONE;
          if (rem == AMT_ONE) begin
            state <= DONE_ST;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE_ST: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  a_busy_done_excl: assert property (@(posedge clk_2) disable iff (!reset_n) !(busy && done));
  a_shift_rem_live: assert property (@(posedge clk_2) disable iff (!reset_n) (state == SHIFT) |-> (rem != '0));

endmodule

// File: tb/tb_universal_shift_engine.sv
// Directed bench for universal_shift_engine (WIDTH=8) with hand-computed results.
module tb_universal_shift_engine;

  logic       clk_2;
  logic       reset_n;
  logic       en;
  logic [2:0] mode;
  logic       serial_in_r;
  logic       serial_in_l;
  logic [7:0] parallel_in;
  logic       start;
  logic [3:0] amount;
  logic [7:0] data_out;
  logic       serial_out_r;
  logic       serial_out_l;
  logic       busy;
  logic       done;

  int tests;
  int failed;
  int n;

  universal_shift_engine #(.WIDTH(8)) dut (
    .clk_2        (clk_2),
    .reset_n      (reset_n),
    .en           (en),
    .mode         (mode),
    .serial_in_r  (serial_in_r),
    .serial_in_l  (serial_in_l),
    .parallel_in  (parallel_in),
    .start        (start),
    .amount       (amount),
    .data_out     (data_out),
    .serial_out_r (serial_out_r),
    .serial_out_l (serial_out_l),
    .busy         (busy),
    .done         (done)
  );

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    en = 1'b1; mode = 3'b101; parallel_in = v;
    tick();
    en = 1'b0;
  endtask

  task automatic start_burst(input logic [2:0] m, input logic [3:0] a);
    start = 1'b1; mode = m; amount = a;
    tick();
    start = 1'b0;
  endtask

  // Steps until done is seen; n counts edges after the start edge.
  task automatic wait_done(input int bound, output int cnt);
    cnt = 0;
    for (int i = 0; i < bound; i++) begin
      tick();
      cnt++;
      if (done) break;
    end
    if (!done) chk("done_timeout", 64'(done), 64'd1);
  endtask

  initial begin
    tests = 0; failed = 0;
    reset_n = 1'b0; en = 1'b0; mode = 3'b000; serial_in_r = 1'b0; serial_in_l = 1'b0;
    parallel_in = 8'h00; start = 1'b0; amount = 4'd0;
    #3;
    chk("rst_data", 64'(data_out), 64'h00);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Parallel load, then a right shift with a 1 entering the MSB
    load(8'hA5);
    chk("load_a5", 64'(data_out), 64'hA5);
    en = 1'b1; mode = 3'b001; serial_in_r = 1'b1;
    tick();
    en = 1'b0; serial_in_r = 1'b0;
    chk("shr_d2", 64'(data_out), 64'hD2);
    chk("sout_r", 64'(serial_out_r), 64'd0);
    chk("sout_l", 64'(serial_out_l), 64'd1);
    mode = 3'b111;
    tick();
    chk("en0_hold", 64'(data_out), 64'hD2);

    // Rotate-right burst of 3
    load(8'h81);
    start_burst(3'b011, 4'd3);
    chk("ror_e0_data", 64'(data_out), 64'h81);
    chk("ror_e0_busy", 64'(busy), 64'd1);
    chk("ror_e0_done", 64'(done), 64'd0);
    tick();
    chk("ror_e1", {busy, data_out}, {1'b1, 8'hC0});
    tick();
    chk("ror_e2", {busy, data_out}, {1'b1, 8'h60});
    tick();
    chk("ror_e3", {busy, done, data_out}, {1'b0, 1'b1, 8'h30});
    tick();
    chk("ror_after", {busy, done}, 2'b00);

    // Arithmetic shift right burst of 2
    load(8'h90);
    start_burst(3'b110, 4'd2);
    tick();
    chk("asr_e1", 64'(data_out), 64'hC8);
    tick();
    chk("asr_e2", {busy, done, data_out}, {1'b0, 1'b1, 8'hE4});
    tick();
    chk("asr_after_done", 64'(done), 64'd0);

    // Zero-length burst
    start_burst(3'b001, 4'd0);
    chk("zero_e0", {busy, done, data_out}, {1'b0, 1'b1, 8'hE4});
    tick();
    chk("zero_after", {busy, done, data_out}, {1'b0, 1'b0, 8'hE4});

    // start/en/mode changes mid-burst are ignored
    load(8'h0F);
    serial_in_l = 1'b0;
    start_burst(3'b010, 4'd3);
    tick();
    chk("mid_e1", 64'(data_out), 64'h1E);
    start = 1'b1; en = 1'b1; mode = 3'b111; amount = 4'd1; parallel_in = 8'hFF;
    tick();
    start = 1'b0; en = 1'b0;
    chk("mid_e2", 64'(data_out), 64'h3C);
    tick();
    chk("mid_e3", {busy, done, data_out}, {1'b0, 1'b1, 8'h78});
    tick();
    chk("mid_after", {busy, done, data_out}, {1'b0, 1'b0, 8'h78});

    // Left-shift fill by 8; busy checked on every intermediate cycle
    en = 1'b1; mode = 3'b111;
    tick();
    en = 1'b0;
    chk("clear", 64'(data_out), 64'h00);
    serial_in_l = 1'b1;
    start_burst(3'b010, 4'd8);
    n = 0;
    for (int i = 1; i < 8; i++) begin
      tick();
      if (busy && !done) n++;
    end
    chk("fill_busy_cycles", 64'(n), 64'd7);
    tick();
    chk("fill8", {busy, done, data_out}, {1'b0, 1'b1, 8'hFF});
    tick();

    // Amount 9 clamps to 8
    en = 1'b1; mode = 3'b111;
    tick();
    en = 1'b0;
    start_burst(3'b010, 4'd9);
    wait_done(20, n);
    chk("clamp_len", 64'(n), 64'd8);
    chk("clamp_data", 64'(data_out), 64'hFF);
    serial_in_l = 1'b0;
    tick();

    // Rotate left by WIDTH restores the original value
    load(8'h5A);
    start_burst(3'b100, 4'd8);
    wait_done(20, n);
    chk("rol8_len", 64'(n), 64'd8);
    chk("rol8_data", 64'(data_out), 64'h5A);
    tick();

    // Reset in the middle of a 5-step burst
    load(8'h33);
    serial_in_r = 1'b0;
    start_burst(3'b001, 4'd5);
    tick();
    chk("rb_e1", 64'(data_out), 64'h19);
    #2 reset_n = 1'b0;
    #1;
    chk("rb_async", {busy, done, data_out}, {1'b0, 1'b0, 8'h00});
    tick();
    reset_n = 1'b1;
    tick();
    chk("rb_no_done1", {busy, done, data_out}, {1'b0, 1'b0, 8'h00});
    tick();
    chk("rb_no_done2", {busy, done}, 2'b00);

    // Fresh burst after reset completes normally
    load(8'hC3);
    start_burst(3'b011, 4'd2);
    wait_done(10, n);
    chk("fresh_len", 64'(n), 64'd2);
    chk("fresh_data", 64'(data_out), 64'hF0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
